// File: rtl/pic_inta_sequencer.sv
// INT/INTA handshake sequencer behind the PIC priority block: raises INT, acks the priority block on
// each INTA pulse and drives {VECTOR_BASE, level} during the second pulse. PIC_CASCADE_EN adds CAS/SLAVE_MASK.
module pic_inta_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int INTA_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] priority_mode_i,
  input  logic [7:0] priority_data_i,
  input  logic       icw_done_i,
  input  logic [4:0] vector_base_i,
  input  logic       inta_n_i,
`ifdef PIC_CASCADE_EN
  input  logic [7:0] slave_mask_i,
  output logic [2:0] cas_o,
`endif
  output logic       int_o,
  output logic [2:0] cu_mode_o,
  output logic [7:0] cu_data_o,
  output logic       cu_write_o,
  output logic [7:0] data_out_o,
  output logic       data_oe_o
);

  localparam logic [2:0] MODE_REQ = 3'b110;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_INT_ASSERTED = 3'd1;
  localparam logic [2:0] ST_ACK1         = 3'd2;
  localparam logic [2:0] ST_WAIT2        = 3'd3;
  localparam logic [2:0] ST_ACK2         = 3'd4;

  localparam int TW = (INTA_TIMEOUT > 0) ? $clog2(INTA_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(INTA_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   inta_s;
  logic                   inta_fall;
  logic                   inta_rise;

  logic [2:0]    state_q, state_d;
  logic [2:0]    level_q, level_d;
  logic          int_q, int_d;
  logic [2:0]    cu_mode_q, cu_mode_d;
  logic [7:0]    cu_data_q, cu_data_d;
  logic          cu_write_q, cu_write_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_oe_q, data_oe_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    ack_level;
  logic [7:0]    slave_mask;
  logic          unused_data_bits;

`ifdef PIC_CASCADE_EN
  logic [2:0] cas_q, cas_d;
  assign slave_mask = slave_mask_i;
`else
  assign slave_mask = 8'h00;
`endif

  assign unused_data_bits = ^priority_data_i[7:3];

  assign inta_s    = sync_q[SYNC_STAGES-1];
  assign inta_fall = dly_q & ~inta_s;
  assign inta_rise = ~dly_q & inta_s;

  // Request gone by the first acknowledge means a spurious interrupt, reported as level 7.
  assign ack_level = (priority_mode_i == MODE_REQ) ? level_q : 3'd7;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n_i};
      dly_q  <= inta_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    int_d      = int_q;
    cu_mode_d  = cu_mode_q;
    cu_data_d  = cu_data_q;
    cu_write_d = 1'b0;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    tmo_d      = tmo_q;
`ifdef PIC_CASCADE_EN
    cas_d      = cas_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (icw_done_i && (priority_mode_i == MODE_REQ)) begin
          level_d = priority_data_i[2:0];
          int_d   = 1'b1;
          state_d = ST_INT_ASSERTED;
        end
      end
      ST_INT_ASSERTED: begin
        if (inta_fall) begin
          cu_write_d = 1'b1;
          cu_mode_d  = MODE_REQ;
          cu_data_d  = {5'b0, ack_level};
          level_d    = ack_level;
          state_d    = ST_ACK1;
`ifdef PIC_CASCADE_EN
          cas_d      = slave_mask_i[ack_level] ? ack_level : 3'd0;
`endif
        end
      end
      ST_ACK1: begin
        if (inta_rise) state_d = ST_WAIT2;
      end
      ST_WAIT2: begin
        if (inta_fall) begin
          int_d      = 1'b0;
          cu_write_d = 1'b1;
          cu_mode_d  = MODE_REQ;
          cu_data_d  = {5'b0, level_q};
          data_out_d = {vector_base_i, level_q};
          data_oe_d  = ~slave_mask[level_q];
          state_d    = ST_ACK2;
        end
      end
      ST_ACK2: begin
        if (inta_rise) begin
          data_oe_d = 1'b0;
          state_d   = ST_IDLE;
`ifdef PIC_CASCADE_EN
          cas_d     = 3'd0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout overrides whatever the handshake would have done on this edge.
    if ((INTA_TIMEOUT > 0) &&
        ((state_q == ST_INT_ASSERTED) || (state_q == ST_ACK1) || (state_q == ST_WAIT2))) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_q == TMO_LAST) begin
        state_d    = ST_IDLE;
        level_d    = level_q;
        int_d      = 1'b0;
        cu_write_d = 1'b0;
        cu_mode_d  = cu_mode_q;
        cu_data_d  = cu_data_q;
        data_out_d = data_out_q;
        data_oe_d  = 1'b0;
`ifdef PIC_CASCADE_EN
        cas_d      = 3'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      level_q    <= 3'd0;
      int_q      <= 1'b0;
      cu_mode_q  <= 3'b000;
      cu_data_q  <= 8'h00;
      cu_write_q <= 1'b0;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      int_q      <= int_d;
      cu_mode_q  <= cu_mode_d;
      cu_data_q  <= cu_data_d;
      cu_write_q <= cu_write_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      tmo_q      <= tmo_d;
    end
  end

`ifdef PIC_CASCADE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cas_q <= 3'd0;
    else       cas_q <= cas_d;
  end

  assign cas_o = cas_q;
`endif

  assign int_o      = int_q;
  assign cu_mode_o  = cu_mode_q;
  assign cu_data_o  = cu_data_q;
  assign cu_write_o = cu_write_q;
  assign data_out_o = data_out_q;
  assign data_oe_o  = data_oe_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Randomized bench for pic_inta_sequencer: each handshake's expected strobes, vector and bus-drive window
// come from the request level, base and INTA pulse widths the bench chose.
module tb_pic_inta_sequencer;

  localparam int TMO = 16;
  localparam logic [2:0] REQ = 3'b110;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] priority_mode;
  logic [7:0] priority_data;
  logic       icw_done;
  logic [4:0] vector_base;
  logic       inta_n;
  logic       int_o;
  logic [2:0] cu_mode;
  logic [7:0] cu_data;
  logic       cu_write;
  logic [7:0] data_out;
  logic       data_oe;
`ifdef PIC_CASCADE_EN
  logic [7:0] slave_mask;
  logic [2:0] cas;
  logic [2:0] exp_cas;
`endif

  int checks = 0;
  int failures = 0;

  // Observations gathered once per cycle on the falling edge.
  int         strobes, consec, unstable, oe_cycles, oe_with_int, cas_bad;
  logic [1:0] int_strb;
  logic [7:0] last_data, oe_data, prev_cu_data;
  logic [2:0] last_mode, prev_cu_mode;
  logic       prev_wr;

  pic_inta_sequencer #(.SYNC_STAGES(2), .INTA_TIMEOUT(TMO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .priority_mode_i (priority_mode),
    .priority_data_i (priority_data),
    .icw_done_i      (icw_done),
    .vector_base_i   (vector_base),
    .inta_n_i        (inta_n),
`ifdef PIC_CASCADE_EN
    .slave_mask_i    (slave_mask),
    .cas_o           (cas),
`endif
    .int_o           (int_o),
    .cu_mode_o       (cu_mode),
    .cu_data_o       (cu_data),
    .cu_write_o      (cu_write),
    .data_out_o      (data_out),
    .data_oe_o       (data_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (cu_write) begin
        if (strobes < 2) int_strb[strobes] = int_o;
        strobes++;
        if (prev_wr) consec++;
        last_data = cu_data;
        last_mode = cu_mode;
`ifdef PIC_CASCADE_EN
        if (cas !== exp_cas) cas_bad++;
`endif
      end else if (cu_data !== prev_cu_data || cu_mode !== prev_cu_mode) begin
        unstable++;
      end
      if (data_oe) begin
        oe_cycles++;
        oe_data = data_out;
        if (int_o) oe_with_int++;
      end
      prev_wr      = cu_write;
      prev_cu_data = cu_data;
      prev_cu_mode = cu_mode;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    strobes = 0; consec = 0; unstable = 0; oe_cycles = 0; oe_with_int = 0; cas_bad = 0;
    int_strb = 2'b00; oe_data = 8'h00; last_data = 8'h00; last_mode = 3'b000;
    prev_wr = 1'b0; prev_cu_data = cu_data; prev_cu_mode = cu_mode;
  endtask

  task automatic wait_int(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (int_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; priority_mode = 3'b000; priority_data = 8'h00; icw_done = 1'b0;
    vector_base = 5'b0; inta_n = 1'b1;
`ifdef PIC_CASCADE_EN
    slave_mask = 8'h00; exp_cas = 3'd0;
`endif
    cyc(3);
    checks++;
    if ({int_o, cu_mode, cu_data, cu_write, data_out, data_oe} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs: int=%b mode=%b data=%h wr=%b out=%h oe=%b required all zero",
               int_o, cu_mode, cu_data, cu_write, data_out, data_oe);
    end
`ifdef PIC_CASCADE_EN
    checks++;
    if (cas !== 3'd0) begin failures++; $display("FAIL reset_cas: cas=%0d required 0", cas); end
`endif
    rst = 1'b0;
    cyc(3);
    checks++;
    if (int_o !== 1'b0 || cu_write !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: int=%b wr=%b required 0 0", int_o, cu_write);
    end
    $display("reset: released, outputs idle");
  endtask

  // One full handshake; expectations derive only from the chosen level/base and pulse widths.
  task automatic run_handshake(input logic [2:0] lvl, input logic [4:0] base, input bit drop,
                               input bit drop_icw, input bit next_req, input logic [2:0] next_lvl,
                               input string name);
    bit ok;
    bit slave;
    logic [2:0] exp_lvl;
    logic [7:0] exp_vec;
    int d1, l1, h1, l2;
    priority_mode = REQ;
    priority_data = {5'($urandom), lvl};
    icw_done = 1'b1;
    vector_base = base;
    wait_int(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s int_rise: int=%b required 1", name, int_o); end
    clr_mon();
    exp_lvl = drop ? 3'd7 : lvl;
    exp_vec = {base, exp_lvl};
    slave = 1'b0;
`ifdef PIC_CASCADE_EN
    slave = slave_mask[exp_lvl];
    exp_cas = slave ? exp_lvl : 3'd0;
`endif
    priority_data = {5'($urandom), 3'($urandom)};
    if (drop) priority_mode = 3'b000;
    if (drop_icw) icw_done = 1'b0;
    d1 = $urandom_range(0, 1); l1 = $urandom_range(2, 3);
    h1 = $urandom_range(2, 3); l2 = $urandom_range(2, 3);
    cyc(d1);
    inta_n = 1'b0; cyc(l1);
    inta_n = 1'b1; cyc(h1);
    inta_n = 1'b0;
    if (next_req) begin
      priority_mode = REQ; priority_data = {5'($urandom), next_lvl}; icw_done = 1'b1;
    end else begin
      priority_mode = 3'b000;
    end
    cyc(l2);
    inta_n = 1'b1;
    cyc(4);
    checks++;
    if (strobes !== 2 || consec !== 0) begin
      failures++;
      $display("FAIL %s strobe_count: strobes=%0d consecutive=%0d required 2 0", name, strobes, consec);
    end
    checks++;
    if (last_mode !== REQ || last_data !== {5'b0, exp_lvl} || unstable !== 0) begin
      failures++;
      $display("FAIL %s ack_cmd: mode=%b data=%h unstable=%0d required %b %h 0",
               name, last_mode, last_data, unstable, REQ, {5'b0, exp_lvl});
    end
    checks++;
    if (int_strb !== 2'b01) begin
      failures++;
      $display("FAIL %s int_at_strobes: got %b required 01 (high at 1st, low at 2nd)", name, int_strb);
    end
    checks++;
    if (slave ? (oe_cycles !== 0)
              : (oe_cycles !== l2 || oe_data !== exp_vec || oe_with_int !== 0)) begin
      failures++;
      $display("FAIL %s vector: oe_cycles=%0d data=%h oe_with_int=%0d required %0d %h 0",
               name, oe_cycles, oe_data, oe_with_int, slave ? 0 : l2, exp_vec);
    end
    checks++;
    if (data_oe !== 1'b0 || int_o !== next_req) begin
      failures++;
      $display("FAIL %s end_state: oe=%b int=%b required 0 %b", name, data_oe, int_o, next_req);
    end
`ifdef PIC_CASCADE_EN
    checks++;
    if (cas_bad !== 0 || cas !== 3'd0) begin
      failures++;
      $display("FAIL %s cas: bad_samples=%0d cas_after=%0d required 0 0", name, cas_bad, cas);
    end
`endif
    $display("%s: lvl=%0d drop=%0b base=%h strobes=%0d vec=%h oe_cycles=%0d",
             name, lvl, drop, base, strobes, oe_data, oe_cycles);
  endtask

  task automatic test_basic();
    run_handshake(3'd3, 5'b01000, 1'b0, 1'b0, 1'b0, 3'd0, "basic_l3");
    run_handshake(3'd3, 5'b01000, 1'b1, 1'b0, 1'b0, 3'd0, "spurious_l7");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_handshake(3'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1) == 1, 1'b0, 3'd0, "random");
  endtask

  task automatic test_back_to_back();
    logic [2:0] a, b;
    a = 3'($urandom); b = 3'($urandom);
    run_handshake(a, 5'($urandom), 1'b0, 1'b0, 1'b1, b, "b2b_first");
    run_handshake(b, 5'($urandom), 1'b0, 1'b0, 1'b0, 3'd0, "b2b_second");
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    priority_mode = REQ; priority_data = {5'b0, 3'($urandom)}; icw_done = 1'b1;
    wait_int(ok);
    clr_mon();
    priority_mode = 3'b000;
    n = ok ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (int_o !== 1'b1) break;
      n++;
    end
    checks++;
    if (n !== TMO) begin
      failures++;
      $display("FAIL timeout_len: int high %0d cycles required %0d", n, TMO);
    end
    inta_n = 1'b0; cyc(3); inta_n = 1'b1; cyc(3);
    inta_n = 1'b0; cyc(3); inta_n = 1'b1; cyc(4);
    checks++;
    if (strobes !== 0 || oe_cycles !== 0 || int_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: strobes=%0d oe_cycles=%0d int=%b required 0 0 0",
               strobes, oe_cycles, int_o);
    end
    $display("timeout: int high %0d cycles, strobes=%0d", n, strobes);
  endtask

  task automatic test_icw_low();
    int highs;
    icw_done = 1'b0; priority_mode = REQ; priority_data = 8'h05;
    clr_mon();
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (int_o !== 1'b0) highs++;
    end
    inta_n = 1'b0; cyc(3); inta_n = 1'b1; cyc(4);
    checks++;
    if (highs !== 0 || strobes !== 0 || oe_cycles !== 0) begin
      failures++;
      $display("FAIL icw_low: int_high_cycles=%0d strobes=%0d oe_cycles=%0d required 0 0 0",
               highs, strobes, oe_cycles);
    end
    priority_mode = 3'b000;
    cyc(1);
    $display("icw_low: int_high_cycles=%0d strobes=%0d", highs, strobes);
  endtask

  task automatic test_reset_mid_ack2();
    bit ok;
    bit seen;
`ifdef PIC_CASCADE_EN
    slave_mask = 8'h00; exp_cas = 3'd0;
`endif
    priority_mode = REQ; priority_data = 8'h02; icw_done = 1'b1; vector_base = 5'b10101;
    wait_int(ok);
    inta_n = 1'b0; cyc(2); inta_n = 1'b1; cyc(2); inta_n = 1'b0;
    priority_mode = 3'b000;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (data_oe === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rst_ack2_reach: oe=%b required 1", data_oe); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (int_o !== 1'b0 || data_oe !== 1'b0 || cu_write !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ack2: int=%b oe=%b wr=%b required 0 0 0", int_o, data_oe, cu_write);
    end
    inta_n = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    $display("reset_mid_ack2: int=%b oe=%b", int_o, data_oe);
  endtask

`ifdef PIC_CASCADE_EN
  task automatic test_cascade();
    slave_mask = 8'h04;
    run_handshake(3'd2, 5'b01000, 1'b0, 1'b0, 1'b0, 3'd0, "cascade_slave_l2");
    run_handshake(3'd5, 5'b01000, 1'b0, 1'b0, 1'b0, 3'd0, "cascade_master_l5");
    for (int i = 0; i < 4; i++) begin
      slave_mask = 8'($urandom);
      run_handshake(3'($urandom), 5'($urandom), $urandom_range(0, 3) == 0, 1'b0, 1'b0, 3'd0,
                    "cascade_random");
    end
    slave_mask = 8'h00;
  endtask
`endif

  initial begin
    clr_mon();
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_timeout();
    test_icw_low();
    test_reset_mid_ack2();
`ifdef PIC_CASCADE_EN
    test_cascade();
`endif
    run_handshake(3'($urandom), 5'($urandom), 1'b0, 1'b0, 1'b0, 3'd0, "after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
